// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and tracker types for the ID-stage hazard controller.
package hazard_ctrl_pkg;

   localparam logic [1:0] READ_NONE = 2'b00;
   localparam logic [1:0] READ_EX   = 2'b01;
   localparam logic [1:0] READ_MEM  = 2'b10;

   localparam logic [1:0] AVAIL_EX  = 2'b01;
   localparam logic [1:0] AVAIL_MEM = 2'b10;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef struct packed {
      logic       valid;
      logic       wr_en;
      logic [4:0] wr_reg;
      logic [1:0] wr_avail;
   } trk_t;

   // Once a producer has left EX its result exists, so availability is no longer tracked.
   typedef struct packed {
      logic       valid;
      logic       wr_en;
      logic [4:0] wr_reg;
   } trk_mem_t;

   function automatic logic [1:0] sel_fwd(input logic m_ex, input logic m_mem);
      return m_ex ? FWD_EXMEM : (m_mem ? FWD_MEMWB : FWD_REG);
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source operand against one in-flight destination entry.
module hazard_match (
   input  logic       valid_i,
   input  logic       wr_en_i,
   input  logic [4:0] wr_reg_i,
   input  logic [4:0] reg_i,
   output logic       match_o
);

   // $0 is hardwired, so a write to it never creates a dependency.
   assign match_o = valid_i & wr_en_i & (wr_reg_i == reg_i) & (reg_i != 5'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use stall plus registered forwarding selects
// that travel with the consumer into EX and MEM.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic        id_flush,
   input  logic [1:0]  id_read_rs,
   input  logic [1:0]  id_read_rt,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_wr_en,
   input  logic [4:0]  id_wr_reg,
   input  logic [1:0]  id_wr_avail,
   output logic        stall,
   output logic [1:0]  fwd_rs_ex,
   output logic [1:0]  fwd_rt_ex,
   output logic        fwd_rt_mem,
   output logic [15:0] stall_count
);

   // The regfile writes before it reads in WB, so nothing older than MEM is tracked.
   trk_t       tex_q, tex_d;
   trk_mem_t   tmem_q;
   logic [1:0] fwd_rs_q, fwd_rs_d;
   logic [1:0] fwd_rt_q, fwd_rt_d;
   logic       pend_q, pend_d;
   logic       fwd_rt_mem_q;
   logic [15:0] stall_count_q;

   logic m_rs_ex, m_rs_mem, m_rt_ex, m_rt_mem;
   logic rs_need_ex, rt_need_ex, rt_need_mem, issue;

   hazard_match u_rs_ex (
      .valid_i (tex_q.valid), .wr_en_i (tex_q.wr_en), .wr_reg_i (tex_q.wr_reg),
      .reg_i   (id_rs),       .match_o (m_rs_ex)
   );
   hazard_match u_rs_mem (
      .valid_i (tmem_q.valid), .wr_en_i (tmem_q.wr_en), .wr_reg_i (tmem_q.wr_reg),
      .reg_i   (id_rs),        .match_o (m_rs_mem)
   );
   hazard_match u_rt_ex (
      .valid_i (tex_q.valid), .wr_en_i (tex_q.wr_en), .wr_reg_i (tex_q.wr_reg),
      .reg_i   (id_rt),       .match_o (m_rt_ex)
   );
   hazard_match u_rt_mem (
      .valid_i (tmem_q.valid), .wr_en_i (tmem_q.wr_en), .wr_reg_i (tmem_q.wr_reg),
      .reg_i   (id_rt),        .match_o (m_rt_mem)
   );

   assign rs_need_ex  = (id_read_rs == READ_EX);
   assign rt_need_ex  = (id_read_rt == READ_EX);
   assign rt_need_mem = (id_read_rt == READ_MEM);

   // Only a load still in EX can't be forwarded in time; MEM-stage readers wait it out.
   assign stall = id_valid & ~id_flush & (tex_q.wr_avail == AVAIL_MEM) &
                  ((rs_need_ex & m_rs_ex) | (rt_need_ex & m_rt_ex));
   assign issue = id_valid & ~id_flush & ~stall;

   always_comb begin
      tex_d    = '0;
      fwd_rs_d = FWD_REG;
      fwd_rt_d = FWD_REG;
      pend_d   = 1'b0;
      if (issue) begin
         tex_d.valid    = 1'b1;
         tex_d.wr_en    = id_wr_en;
         tex_d.wr_reg   = id_wr_reg;
         tex_d.wr_avail = id_wr_avail;
         if (rs_need_ex)
            fwd_rs_d = sel_fwd(m_rs_ex, m_rs_mem);
         if (rt_need_ex) begin
            fwd_rt_d = sel_fwd(m_rt_ex, m_rt_mem);
         end else if (rt_need_mem) begin
            // Store data from the instruction just ahead is picked up one stage later, in MEM.
            if (m_rt_ex)
               pend_d = 1'b1;
            else if (m_rt_mem)
               fwd_rt_d = FWD_MEMWB;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tex_q         <= '0;
         tmem_q        <= '0;
         fwd_rs_q      <= FWD_REG;
         fwd_rt_q      <= FWD_REG;
         pend_q        <= 1'b0;
         fwd_rt_mem_q  <= 1'b0;
         stall_count_q <= '0;
      end else begin
         tex_q         <= tex_d;
         tmem_q.valid  <= tex_q.valid;
         tmem_q.wr_en  <= tex_q.wr_en;
         tmem_q.wr_reg <= tex_q.wr_reg;
         fwd_rs_q      <= fwd_rs_d;
         fwd_rt_q      <= fwd_rt_d;
         pend_q        <= pend_d;
         fwd_rt_mem_q  <= pend_q;
         if (stall && stall_count_q != 16'hFFFF)
            stall_count_q <= stall_count_q + 16'd1;
      end
   end

   assign fwd_rs_ex   = fwd_rs_q;
   assign fwd_rt_ex   = fwd_rt_q;
   assign fwd_rt_mem  = fwd_rt_mem_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table with a select scoreboard, then reset and
// counter-saturation sequences.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_flush, id_wr_en;
   logic [1:0]  id_read_rs, id_read_rt, id_wr_avail;
   logic [4:0]  id_rs, id_rt, id_wr_reg;
   logic        stall, fwd_rt_mem;
   logic [1:0]  fwd_rs_ex, fwd_rt_ex;
   logic [15:0] stall_count;

   int checks = 0;
   int errors = 0;

   hazard_ctrl dut (
      .clk (clk), .rst (rst),
      .id_valid (id_valid), .id_flush (id_flush),
      .id_read_rs (id_read_rs), .id_read_rt (id_read_rt),
      .id_rs (id_rs), .id_rt (id_rt),
      .id_wr_en (id_wr_en), .id_wr_reg (id_wr_reg), .id_wr_avail (id_wr_avail),
      .stall (stall), .fwd_rs_ex (fwd_rs_ex), .fwd_rt_ex (fwd_rt_ex),
      .fwd_rt_mem (fwd_rt_mem), .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v, fl;
      logic [1:0] crs;
      logic [4:0] rs;
      logic [1:0] crt;
      logic [4:0] rt;
      logic       we;
      logic [4:0] wr;
      logic [1:0] av;
      logic       st;    // expected stall this cycle
      logic [1:0] ers;   // selects loaded into EX from this cycle
      logic [1:0] ert;
      logic       emem;  // fwd_rt_mem one cycle after that
   } vec_t;

   typedef struct {
      logic [1:0] rs, rt;
      logic       mem;
      int         id;
   } exp_t;

   vec_t vecs[$];
   exp_t ex_q[$];
   exp_t mem_q[$];

   function automatic vec_t mk(input logic v, fl, input logic [1:0] crs, input logic [4:0] rs,
                               input logic [1:0] crt, input logic [4:0] rt, input logic we,
                               input logic [4:0] wr, input logic [1:0] av, input logic st,
                               input logic [1:0] ers, ert, input logic emem);
      vec_t t;
      t.v = v; t.fl = fl; t.crs = crs; t.rs = rs; t.crt = crt; t.rt = rt;
      t.we = we; t.wr = wr; t.av = av; t.st = st; t.ers = ers; t.ert = ert; t.emem = emem;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      id_valid = t.v; id_flush = t.fl; id_read_rs = t.crs; id_rs = t.rs;
      id_read_rt = t.crt; id_rt = t.rt; id_wr_en = t.we; id_wr_reg = t.wr; id_wr_avail = t.av;
   endtask

   initial begin
      vec_t idle;
      vec_t lw22, use22;
      exp_t e;
      idle = mk(0,0, 2'b00,0, 2'b00,0, 0,0, 2'b00, 0, 2'b00,2'b00,0);

      //          v fl crs rs  crt rt  we wr  av     st ers    ert    mem
      vecs.push_back(mk(1,0, 2'b01, 1, 2'b01, 2, 1, 3, 2'b01, 0, 2'b00,2'b00,0)); // add $3
      vecs.push_back(mk(1,0, 2'b01, 3, 2'b01, 9, 1, 8, 2'b01, 0, 2'b01,2'b00,0)); // sub uses $3
      vecs.push_back(mk(1,0, 2'b01, 1, 2'b00, 0, 1, 4, 2'b10, 0, 2'b00,2'b00,0)); // lw $4
      vecs.push_back(mk(1,0, 2'b01, 2, 2'b01, 4, 1,10, 2'b01, 1, 2'b00,2'b00,0)); // add uses $4: stall
      vecs.push_back(mk(1,0, 2'b01, 2, 2'b01, 4, 1,10, 2'b01, 0, 2'b00,2'b10,0)); // re-issue
      vecs.push_back(mk(1,0, 2'b01, 1, 2'b00, 0, 1, 5, 2'b10, 0, 2'b00,2'b00,0)); // lw $5
      vecs.push_back(mk(1,0, 2'b01, 6, 2'b10, 5, 0, 0, 2'b00, 0, 2'b00,2'b00,1)); // sw rt=$5
      vecs.push_back(mk(1,0, 2'b01, 1, 2'b00, 0, 1, 0, 2'b10, 0, 2'b00,2'b00,0)); // lw $0
      vecs.push_back(mk(1,0, 2'b01, 0, 2'b01, 0, 0, 0, 2'b00, 0, 2'b00,2'b00,0)); // reads $0
      vecs.push_back(mk(1,0, 2'b01, 1, 2'b00, 0, 1, 7, 2'b01, 0, 2'b00,2'b00,0)); // add $7
      vecs.push_back(idle);                                                       // bubble
      vecs.push_back(mk(1,0, 2'b01, 7, 2'b10, 7, 0, 0, 2'b00, 0, 2'b10,2'b10,0)); // reads $7
      vecs.push_back(mk(1,0, 2'b01, 1, 2'b00, 0, 1,12, 2'b10, 0, 2'b00,2'b00,0)); // lw $12
      vecs.push_back(mk(1,1, 2'b01,12, 2'b00,12, 0, 0, 2'b00, 0, 2'b00,2'b00,0)); // use, flushed
      vecs.push_back(mk(1,0, 2'b01,12, 2'b00,12, 0, 0, 2'b00, 0, 2'b10,2'b00,0)); // use again
      vecs.push_back(mk(1,0, 2'b01, 1, 2'b00, 0, 1,14, 2'b01, 0, 2'b00,2'b00,0)); // add $14
      vecs.push_back(mk(1,0, 2'b01, 1, 2'b00, 0, 1,14, 2'b01, 0, 2'b00,2'b00,0)); // add $14 again
      vecs.push_back(mk(1,0, 2'b01,14, 2'b01,14, 0, 0, 2'b00, 0, 2'b01,2'b01,0)); // youngest wins
      vecs.push_back(mk(1,0, 2'b01, 1, 2'b00, 0, 1,20, 2'b10, 0, 2'b00,2'b00,0)); // lw $20
      vecs.push_back(mk(0,0, 2'b01,20, 2'b01,20, 0, 0, 2'b00, 0, 2'b00,2'b00,0)); // invalid use
      vecs.push_back(mk(1,0, 2'b00,20, 2'b10,20, 0, 0, 2'b00, 0, 2'b00,2'b10,0)); // sw from MEM/WB
      vecs.push_back(idle);

      rst = 1'b1;
      drive(idle);
      #1;
      chk("reset stall", stall, 0);
      chk("reset fwd_rs_ex", fwd_rs_ex, 0);
      chk("reset fwd_rt_ex", fwd_rt_ex, 0);
      chk("reset fwd_rt_mem", fwd_rt_mem, 0);
      chk("reset stall_count", stall_count, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size() + 2; i++) begin
         @(negedge clk);
         if (mem_q.size() > 0) begin
            e = mem_q.pop_front();
            chk($sformatf("vec%0d fwd_rt_mem", e.id), fwd_rt_mem, e.mem);
         end
         if (ex_q.size() > 0) begin
            e = ex_q.pop_front();
            chk($sformatf("vec%0d fwd_rs_ex", e.id), fwd_rs_ex, e.rs);
            chk($sformatf("vec%0d fwd_rt_ex", e.id), fwd_rt_ex, e.rt);
            mem_q.push_back(e);
         end
         if (i < vecs.size()) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d stall", i), stall, vecs[i].st);
            e.rs = vecs[i].ers; e.rt = vecs[i].ert; e.mem = vecs[i].emem; e.id = i;
            ex_q.push_back(e);
         end else begin
            drive(idle);
         end
      end
      chk("table stall_count", stall_count, 1);

      // Reset in the middle of a load-use stall.
      lw22  = mk(1,0, 2'b01, 1, 2'b00, 0, 1,22, 2'b10, 0, 2'b00,2'b00,0);
      use22 = mk(1,0, 2'b01,22, 2'b00, 0, 1,23, 2'b01, 0, 2'b00,2'b00,0);
      @(negedge clk);
      drive(lw22);
      @(negedge clk);
      drive(use22);
      #1;
      chk("midstall stall before rst", stall, 1);
      #1;
      rst = 1'b1;
      #1;
      chk("midstall stall after rst", stall, 0);
      chk("midstall count after rst", stall_count, 0);
      chk("midstall fwd_rs_ex after rst", fwd_rs_ex, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reissue stall", stall, 0);
      @(negedge clk);
      chk("reissue fwd_rs_ex", fwd_rs_ex, 2'b00);
      drive(idle);

      // Preload the counter just below the top so saturation is reached in a few pairs.
      @(negedge clk);
      force dut.stall_count_q = 16'hFFFD;
      #1;
      release dut.stall_count_q;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         if (j == 1) chk("sat count 1", stall_count, 16'hFFFE);
         if (j >= 2) chk($sformatf("sat count %0d", j), stall_count, 16'hFFFF);
         drive(lw22);
         @(negedge clk);
         drive(use22);
         #1;
         chk($sformatf("sat stall %0d", j), stall, 1);
      end
      @(negedge clk);
      drive(idle);
      chk("sat count final", stall_count, 16'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller sitting in the ID stage, directly downstream of the per-instruction register-read decoder. It consumes the decoder's 2-bit read-stage codes for rs/rt plus the instruction's destination info. It tracks destination registers of in-flight instructions in EX, MEM and WB, raises a one-cycle load-use stall when forwarding cannot cover a dependency, and issues registered forwarding selects that travel with the consumer into EX and MEM.

## Interface
- No parameters.
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_flush  in  1  squash ID instruction this cycle (taken branch/jump)
- id_read_rs  in  2  rs read code: 00 none, 01 needed at EX, 10 needed at MEM
- id_read_rt  in  2  rt read code, same encoding
- id_rs, id_rt  in  5 each  source register numbers
- id_wr_en  in  1  instruction writes a register
- id_wr_reg  in  5  destination register
- id_wr_avail  in  2  result ready: 01 end of EX (ALU), 10 end of MEM (load)
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- fwd_rs_ex, fwd_rt_ex  out  2 each  EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- fwd_rt_mem  out  1  MEM store-data select: 0 pipelined rt, 1 MEM/WB result
- stall_count  out  16  saturating count of stall cycles

## Operation
- Trackers T_EX, T_MEM, T_WB each hold {valid, wr_en, wr_reg, wr_avail}. An entry with wr_reg == 0 never matches.
- match(X, r) = X.valid & X.wr_en & X.wr_reg == r & r != 0. Only operands with read code != 00 are checked.
- Stall is combinational: stall = id_valid & ~id_flush & ∃ operand with read code 01 and match(T_EX, reg) and T_EX.wr_avail == 10. Read code 10 never stalls.
- Advance every cycle: T_WB <= T_MEM; T_MEM <= T_EX; T_EX <= ID info if id_valid & ~id_flush & ~stall, else bubble (valid = 0).
- Forward selects are computed at advance and registered with the consumer. Priority is youngest first:
  - For an operand with code 01: match(T_EX) gives fwd 01; else match(T_MEM) gives fwd 10; else 00.
  - For rt with code 10: match(T_EX) sets fwd_rt_mem_pending = 1 and fwd_rt_ex = 00; else match(T_MEM) gives fwd_rt_ex = 10; else 00.
- fwd_rt_mem_pending shifts one stage, so fwd_rt_mem is asserted while the consumer is in MEM.
- Bubbles and squashed instructions load all-zero selects.
- stall_count increments on each cycle with stall = 1 and saturates at 16'hFFFF.
- id_flush and stall together: flush wins, stall = 0, bubble enters EX.

## Timing
- Reset (async): all trackers invalid. fwd_rs_ex = fwd_rt_ex = 00, fwd_rt_mem = 0, stall_count = 0. stall then evaluates to 0 by construction.
- stall: zero latency, same cycle as the ID inputs. Asserted for exactly one cycle per load-use pair, because the load moves to MEM and the bubble fills EX.
- fwd_*_ex are valid the cycle the consumer is in EX, one cycle after its ID cycle (excluding stall cycles).
- fwd_rt_mem is valid one cycle later, while the consumer is in MEM.
- The register file is write-before-read in WB, so no WB-to-ID forward is generated.
- Reset mid-stall: trackers clear and the stall drops asynchronously. The held instruction then re-issues with regfile selects.

## Structure
- Shared header constants: READ_NONE/READ_EX/READ_MEM (00/01/10), AVAIL_EX/AVAIL_MEM, FWD_REG/FWD_EXMEM/FWD_MEMWB (00/01/10).
- One sub-module, hazard_match: the comparator for one operand against one tracker entry (valid/wr_en/zero-reg gating). It is instantiated 4x: rs/rt × T_EX/T_MEM.
- The trackers and select pipeline live in hazard_ctrl itself.

## Test plan
- add $3 at cycle 0, then sub using $3 (rs code 01) at cycle 1 -> stall = 0; fwd_rs_ex = 01 in cycle 2.
- lw $4 at cycle 0, then add using $4 (rt code 01) at cycle 1 -> stall = 1 in cycle 1 only; stall_count = 1; fwd_rt_ex = 10 in cycle 3.
- lw $5 at cycle 0, then sw with rt = $5 (code 10) at cycle 1 -> no stall; fwd_rt_ex = 00 in cycle 2; fwd_rt_mem = 1 in cycle 3.
- Writer of $0, then a reader of $0; and a writer of $7 with a bubble, then a reader of $7 two cycles later -> $0 case: selects 00, no stall. $7 case: fwd 10.
- Load-use pair with id_flush = 1 in the stall cycle -> stall = 0; a bubble enters EX; stall_count unchanged.
- Assert rst while stall = 1 -> outputs 0 immediately; stall_count = 0. Force 65536 stall cycles -> stall_count holds 16'hFFFF.
